// File: rtl/axi4lite_mem_ctrl_if.sv
// axi4lite_mem_ctrl_if: AXI4-Lite five-channel bundle between a bus master and the memory front end.
interface axi4lite_mem_ctrl_if #(
    parameter int dataWidth    = 32,
    parameter int axiAddrWidth = 32
);
    localparam int strbWidth = dataWidth / 8;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [axiAddrWidth-1:0] AWADDR;
    logic                    WVALID;
    logic                    WREADY;
    logic [dataWidth-1:0]    WDATA;
    logic [strbWidth-1:0]    WSTRB;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [axiAddrWidth-1:0] ARADDR;
    logic                    RVALID;
    logic                    RREADY;
    logic [dataWidth-1:0]    RDATA;
    logic [1:0]              RRESP;
    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi4lite_mem_ctrl.sv
// axi4lite_mem_ctrl: AXI4-Lite slave driving a byte-strobed word memory with independent read/write FSMs.
module axi4lite_mem_ctrl #(
    parameter int dataWidth    = 32,
    parameter int dataDepth    = 64,
    parameter int addrWidth    = $clog2(dataDepth),
    parameter int strbWidth    = dataWidth / 8,
    parameter int axiAddrWidth = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    axi4lite_mem_ctrl_if.slave    axi,
    output logic                  mem_WEN,
    output logic [addrWidth-1:0]  mem_AWADDR,
    output logic [strbWidth-1:0]  mem_WSTRB,
    output logic [dataWidth-1:0]  mem_WDATA,
    output logic                  mem_REN,
    output logic [addrWidth-1:0]  mem_ARADDR,
    input  logic [dataWidth-1:0]  mem_RDATA
);
    localparam int LSB = $clog2(strbWidth);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_MEM, R_VALID} r_state_t;

    function automatic logic [addrWidth-1:0] f_idx(input logic [axiAddrWidth-1:0] a);
        return a[LSB +: addrWidth];
    endfunction

    function automatic logic f_oor(input logic [axiAddrWidth-1:0] a);
        return (a >> (addrWidth + LSB)) != '0;
    endfunction

    w_state_t             r_wstate, w_wstate_n;
    logic                 r_aw_held, w_aw_held_n, r_w_held, w_w_held_n;
    logic [addrWidth-1:0] r_aw_idx, w_aw_idx_n;
    logic                 r_aw_oor, w_aw_oor_n;
    logic [dataWidth-1:0] r_wdata, w_wdata_n;
    logic [strbWidth-1:0] r_wstrb, w_wstrb_n;
    logic                 r_awready, w_awready_n, r_wready, w_wready_n;
    logic                 r_bvalid, w_bvalid_n, r_wen, w_wen_n;
    logic [1:0]           r_bresp, w_bresp_n;
    logic                 w_aw_hs, w_w_hs, w_b_hs;

    r_state_t             r_rstate, w_rstate_n;
    logic [addrWidth-1:0] r_ar_idx, w_ar_idx_n;
    logic                 r_ar_oor, w_ar_oor_n;
    logic                 r_arready, w_arready_n, r_ren, w_ren_n, r_rvalid, w_rvalid_n;
    logic [1:0]           r_rresp, w_rresp_n;
    logic                 w_ar_hs, w_r_hs;

    // Registered outputs are derived from next-state values so they line up with the state they describe.
    always_comb begin
        w_aw_hs     = axi.AWVALID && r_awready;
        w_w_hs      = axi.WVALID && r_wready;
        w_b_hs      = r_bvalid && axi.BREADY;
        w_aw_held_n = !w_b_hs && (r_aw_held || w_aw_hs);
        w_w_held_n  = !w_b_hs && (r_w_held || w_w_hs);
        w_aw_idx_n  = w_aw_hs ? f_idx(axi.AWADDR) : r_aw_idx;
        w_aw_oor_n  = w_aw_hs ? f_oor(axi.AWADDR) : r_aw_oor;
        w_wdata_n   = w_w_hs ? axi.WDATA : r_wdata;
        w_wstrb_n   = w_w_hs ? axi.WSTRB : r_wstrb;
        w_wstate_n  = (r_wstate == W_IDLE && w_aw_held_n && w_w_held_n) ? W_EXEC :
                      (r_wstate == W_EXEC)                              ? W_RESP :
                      (r_wstate == W_RESP && w_b_hs)                    ? W_IDLE : r_wstate;
        w_awready_n = (w_wstate_n == W_IDLE) && !w_aw_held_n;
        w_wready_n  = (w_wstate_n == W_IDLE) && !w_w_held_n;
        w_wen_n     = (w_wstate_n == W_EXEC) && !w_aw_oor_n;
        w_bvalid_n  = (w_wstate_n == W_RESP);
        w_bresp_n   = (w_bvalid_n && w_aw_oor_n) ? 2'b10 : 2'b00;
    end

    always_comb begin
        w_ar_hs     = axi.ARVALID && r_arready;
        w_r_hs      = r_rvalid && axi.RREADY;
        w_ar_idx_n  = w_ar_hs ? f_idx(axi.ARADDR) : r_ar_idx;
        w_ar_oor_n  = w_ar_hs ? f_oor(axi.ARADDR) : r_ar_oor;
        w_rstate_n  = (r_rstate == R_IDLE && w_ar_hs)  ? R_MEM   :
                      (r_rstate == R_MEM)              ? R_VALID :
                      (r_rstate == R_VALID && w_r_hs)  ? R_IDLE  : r_rstate;
        w_arready_n = (w_rstate_n == R_IDLE);
        w_ren_n     = (w_rstate_n == R_MEM) && !w_ar_oor_n;
        w_rvalid_n  = (w_rstate_n == R_VALID);
        w_rresp_n   = (w_rvalid_n && w_ar_oor_n) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_oor  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_wen     <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_n;
            r_aw_held <= w_aw_held_n;
            r_w_held  <= w_w_held_n;
            r_aw_idx  <= w_aw_idx_n;
            r_aw_oor  <= w_aw_oor_n;
            r_wdata   <= w_wdata_n;
            r_wstrb   <= w_wstrb_n;
            r_awready <= w_awready_n;
            r_wready  <= w_wready_n;
            r_bvalid  <= w_bvalid_n;
            r_bresp   <= w_bresp_n;
            r_wen     <= w_wen_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rstate  <= R_IDLE;
            r_ar_idx  <= '0;
            r_ar_oor  <= 1'b0;
            r_arready <= 1'b0;
            r_ren     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
        end else begin
            r_rstate  <= w_rstate_n;
            r_ar_idx  <= w_ar_idx_n;
            r_ar_oor  <= w_ar_oor_n;
            r_arready <= w_arready_n;
            r_ren     <= w_ren_n;
            r_rvalid  <= w_rvalid_n;
            r_rresp   <= w_rresp_n;
        end
    end

    assign axi.AWREADY = r_awready;
    assign axi.WREADY  = r_wready;
    assign axi.BVALID  = r_bvalid;
    assign axi.BRESP   = r_bresp;
    assign axi.ARREADY = r_arready;
    assign axi.RVALID  = r_rvalid;
    assign axi.RRESP   = r_rresp;
    // Memory output is registered and not re-read while RVALID is up, so passing it through stays stable.
    assign axi.RDATA   = (r_rvalid && !r_ar_oor) ? mem_RDATA : '0;
    assign mem_WEN     = r_wen;
    assign mem_AWADDR  = r_aw_idx;
    assign mem_WSTRB   = r_wstrb;
    assign mem_WDATA   = r_wdata;
    assign mem_REN     = r_ren;
    assign mem_ARADDR  = r_ar_idx;
endmodule

// File: tb/tb_axi4lite_mem_ctrl.sv
// tb_axi4lite_mem_ctrl: scoreboard bench for the AXI4-Lite memory front end with a read-before-write memory model.
module tb_axi4lite_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_WEN, mem_REN;
    logic [5:0]  mem_AWADDR, mem_ARADDR;
    logic [3:0]  mem_WSTRB;
    logic [31:0] mem_WDATA;
    logic [31:0] mem_RDATA = '0;
    logic [31:0] mem [64];
    int          n_tests = 0;
    int          n_fail = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    axi4lite_mem_ctrl_if #(.dataWidth(32), .axiAddrWidth(32)) axi();

    axi4lite_mem_ctrl #(.dataWidth(32), .dataDepth(64), .axiAddrWidth(32)) dut (
        .clk(clk), .reset(reset), .axi(axi),
        .mem_WEN(mem_WEN), .mem_AWADDR(mem_AWADDR), .mem_WSTRB(mem_WSTRB), .mem_WDATA(mem_WDATA),
        .mem_REN(mem_REN), .mem_ARADDR(mem_ARADDR), .mem_RDATA(mem_RDATA)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    always @(posedge clk) begin
        if (mem_REN) mem_RDATA <= mem[mem_ARADDR];
        if (mem_WEN)
            for (int b = 0; b < 4; b++)
                if (mem_WSTRB[b]) mem[mem_AWADDR][8*b +: 8] <= mem_WDATA[8*b +: 8];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_WEN) wen_cnt++;
            if (mem_REN) ren_cnt++;
            if (axi.BVALID && axi.BREADY) begin
                if (bq.size() == 0) check("unexpected_b", 1, 0);
                else check("bresp", {62'd0, axi.BRESP}, {62'd0, bq.pop_front()});
            end
            if (axi.RVALID && axi.RREADY) begin
                if (rq.size() == 0) check("unexpected_r", 1, 0);
                else check("rresp_rdata", {30'd0, axi.RRESP, axi.RDATA}, {30'd0, rq.pop_front()});
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input bit push, input bit lat);
        logic aw_go, w_go;
        @(posedge clk); #1;
        if (push) bq.push_back(resp);
        axi.AWADDR = addr; axi.WDATA = data; axi.WSTRB = strb;
        axi.AWVALID = 1'b1; axi.WVALID = 1'b1;
        for (int i = 0; i < 20 && (axi.AWVALID || axi.WVALID); i++) begin
            @(negedge clk);
            aw_go = axi.AWVALID && axi.AWREADY;
            w_go  = axi.WVALID && axi.WREADY;
            @(posedge clk); #1;
            if (aw_go) axi.AWVALID = 1'b0;
            if (w_go) axi.WVALID = 1'b0;
        end
        check("aw_w_accepted", {axi.AWVALID, axi.WVALID}, 0);
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
        if (lat) begin
            @(negedge clk);
            check("w_exec_cycle", {mem_WEN, mem_AWADDR, axi.BVALID}, {resp == 2'b00, addr[7:2], 1'b0});
            @(negedge clk);
            check("w_resp_cycle", {mem_WEN, axi.BVALID}, 2'b01);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input bit push, input bit lat);
        logic ar_go;
        @(posedge clk); #1;
        if (push) rq.push_back({resp, data});
        axi.ARADDR = addr; axi.ARVALID = 1'b1;
        for (int i = 0; i < 20 && axi.ARVALID; i++) begin
            @(negedge clk);
            ar_go = axi.ARREADY;
            @(posedge clk); #1;
            if (ar_go) axi.ARVALID = 1'b0;
        end
        check("ar_accepted", {63'd0, axi.ARVALID}, 0);
        axi.ARVALID = 1'b0;
        if (lat) begin
            @(negedge clk);
            check("r_mem_cycle", {mem_REN, mem_ARADDR, axi.RVALID}, {resp == 2'b00, addr[7:2], 1'b0});
            @(negedge clk);
            check("r_valid_cycle", {mem_REN, axi.RVALID}, 2'b01);
        end
    endtask

    task automatic wait_b();
        for (int i = 0; i < 30 && bq.size() != 0; i++) @(posedge clk);
        check("b_drained", bq.size(), 0);
        #1;
    endtask

    task automatic wait_r();
        for (int i = 0; i < 30 && rq.size() != 0; i++) @(posedge clk);
        check("r_drained", rq.size(), 0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, rc;
        reset = 1'b0;
        axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
        axi.AWADDR = '0; axi.WDATA = '0; axi.WSTRB = '0; axi.ARADDR = '0;
        axi.BREADY = 1'b1; axi.RREADY = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outs", {axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID, mem_WEN, mem_REN}, 0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_reset", {axi.AWREADY, axi.WREADY, axi.ARREADY, axi.BVALID, axi.RVALID, axi.BRESP, axi.RRESP},
              {3'b111, 2'b00, 4'b0000});

        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 1, 1);
        wait_b();
        axi_read(32'h08, 32'hDEADBEEF, 2'b00, 1, 1);
        wait_r();

        axi_write(32'h10, 32'h11223344, 4'hF, 2'b00, 1, 1);
        wait_b();
        @(posedge clk); #1;
        axi.WDATA = 32'h0000AB00; axi.WSTRB = 4'b0010; axi.WVALID = 1'b1;
        @(negedge clk);
        check("w_first_ready", {63'd0, axi.WREADY}, 1);
        @(posedge clk); #1 axi.WVALID = 1'b0;
        bq.push_back(2'b00);
        repeat (3) begin
            @(negedge clk);
            check("w_held_wait", {mem_WEN, axi.WREADY, axi.AWREADY, axi.BVALID}, 4'b0010);
        end
        @(posedge clk); #1;
        axi.AWADDR = 32'h10; axi.AWVALID = 1'b1;
        @(negedge clk);
        check("aw_late_ready", {63'd0, axi.AWREADY}, 1);
        @(posedge clk); #1 axi.AWVALID = 1'b0;
        @(negedge clk);
        check("aw_late_exec", {mem_WEN, mem_AWADDR, mem_WSTRB}, {1'b1, 6'd4, 4'b0010});
        wait_b();
        axi_read(32'h10, 32'h1122AB44, 2'b00, 1, 1);
        wait_r();

        wc = wen_cnt; rc = ren_cnt;
        axi_write(32'h100, 32'h12345678, 4'hF, 2'b10, 1, 1);
        wait_b();
        check("oor_no_wen", wen_cnt - wc, 0);
        axi_read(32'h100, 32'h0, 2'b10, 1, 1);
        wait_r();
        check("oor_no_ren", ren_cnt - rc, 0);

        fork
            axi_write(32'h08, 32'hCAFEF00D, 4'hF, 2'b00, 1, 1);
            axi_read(32'h08, 32'hDEADBEEF, 2'b00, 1, 1);
        join
        wait_b();
        wait_r();
        axi_read(32'h08, 32'hCAFEF00D, 2'b00, 1, 1);
        wait_r();

        axi.BREADY = 1'b0;
        axi_write(32'h0C, 32'h5A5A5A5A, 4'hF, 2'b00, 1, 1);
        repeat (5) begin
            @(negedge clk);
            check("b_stall", {axi.BVALID, axi.BRESP, axi.AWREADY, axi.WREADY}, 5'b10000);
        end
        @(posedge clk); #1 axi.BREADY = 1'b1;
        wait_b();
        axi.RREADY = 1'b0;
        axi_read(32'h0C, 32'h5A5A5A5A, 2'b00, 1, 1);
        repeat (5) begin
            @(negedge clk);
            check("r_stall", {axi.RVALID, axi.RDATA, axi.RRESP, axi.ARREADY}, {1'b1, 32'h5A5A5A5A, 2'b00, 1'b0});
        end
        @(posedge clk); #1 axi.RREADY = 1'b1;
        wait_r();

        axi.BREADY = 1'b0;
        axi_write(32'h14, 32'h77777777, 4'hF, 2'b00, 0, 0);
        for (int i = 0; i < 10 && !axi.BVALID; i++) @(negedge clk);
        check("bvalid_before_reset", {63'd0, axi.BVALID}, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("w_reset_clear", {axi.BVALID, axi.AWREADY, axi.WREADY}, 0);
        @(posedge clk); #1 axi.BREADY = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("w_no_resp_after_reset", {axi.BVALID, axi.AWREADY, axi.WREADY}, 3'b011);
        end
        axi_write(32'h14, 32'h0BADCAFE, 4'hF, 2'b00, 1, 1);
        wait_b();

        axi_read(32'h14, 32'h0, 2'b00, 0, 0);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("r_no_resp_after_reset", {63'd0, axi.RVALID}, 0);
        end
        check("arready_after_reset", {63'd0, axi.ARREADY}, 1);
        axi_read(32'h14, 32'h0BADCAFE, 2'b00, 1, 1);
        wait_r();

        repeat (3) @(posedge clk);
        check("queues_empty", bq.size() + rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4lite_mem_ctrl.md
Name: axi4lite_mem_ctrl

Overview:
- AXI4-Lite slave front end that sits directly upstream of the team's byte-strobed, single-cycle-read word memory.
- Terminates the five AXI4-Lite channels and converts byte addresses to word indices.
- Drives the memory's write port (WEN/AWADDR/WSTRB/WDATA) and read port (REN/ARADDR), and returns the memory's registered RDATA on the R channel.
- Read and write paths are independent FSMs and may run concurrently.

Parameters:
- dataWidth, 32, AXI data width and memory word width; multiple of 8.
- dataDepth, 64, number of memory words.
- addrWidth, $clog2(dataDepth), memory word-index width.
- strbWidth, dataWidth/8, byte-strobe width.
- axiAddrWidth, 32, AXI byte-address width; must be ≥ addrWidth+$clog2(strbWidth).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- AWVALID  in  1  write-address valid.
- AWREADY  out  1  write-address ready.
- AWADDR  in  axiAddrWidth  write byte address.
- WVALID  in  1  write-data valid.
- WREADY  out  1  write-data ready.
- WDATA  in  dataWidth  write data.
- WSTRB  in  strbWidth  write byte strobes.
- BVALID  out  1  write-response valid.
- BREADY  in  1  write-response ready.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- ARVALID  in  1  read-address valid.
- ARREADY  out  1  read-address ready.
- ARADDR  in  axiAddrWidth  read byte address.
- RVALID  out  1  read-data valid.
- RREADY  in  1  read-data ready.
- RDATA  out  dataWidth  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- mem_WEN  out  1  memory write enable.
- mem_AWADDR  out  addrWidth  memory write word index.
- mem_WSTRB  out  strbWidth  memory byte strobes.
- mem_WDATA  out  dataWidth  memory write data.
- mem_REN  out  1  memory read enable.
- mem_ARADDR  out  addrWidth  memory read word index.
- mem_RDATA  in  dataWidth  memory registered read data; valid the cycle after mem_REN.

Behaviour:
- Reset (reset=0 at a clk edge): outputs forced as follows; reset overrides everything, and in-flight transactions are dropped silently with no B or R response.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_WEN, mem_REN = 0.
  - BRESP, RRESP = 00.
  - Held address/data/strobe registers cleared to 0.
  - Both FSMs return to IDLE.
- All READY/VALID outputs and mem_* outputs are registered.
- READYs rise in the first cycle after reset returns high.
- Word index = byte address bits [addrWidth+$clog2(strbWidth)-1 : $clog2(strbWidth)]. Low byte-offset bits are ignored.
- Out of range: any byte-address bit above the index field is nonzero.
- Write FSM states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE: AWREADY=1 while no address is held; WREADY=1 while no data is held.
  - AW and W handshakes are accepted independently, in either order or on the same edge. Each READY drops the cycle after its own handshake.
  - When both address and data are held, go to W_EXEC.
  - W_EXEC lasts exactly 1 cycle:
    - mem_AWADDR, mem_WDATA and mem_WSTRB carry the held values.
    - mem_WEN=1 only if the address is in range.
    - Next state is W_RESP.
  - W_RESP: BVALID=1; BRESP=00, or 10 if the address was out of range. BVALID/BRESP are held stable until BVALID&&BREADY.
  - On the B handshake edge: go to W_IDLE and clear the held flags; AWREADY=WREADY=1 the next cycle.
  - Minimum latency: AW and W on edge E0 → mem_WEN high in cycle after E0 → BVALID high in cycle after E1.
- Read FSM states R_IDLE, R_MEM, R_VALID:
  - R_IDLE: ARREADY=1. On AR handshake, latch the address, set ARREADY=0 and go to R_MEM.
  - R_MEM lasts exactly 1 cycle: mem_ARADDR = latched index; mem_REN=1 only if the address is in range.
  - R_VALID:
    - RVALID=1.
    - In range: RDATA=mem_RDATA, RRESP=00.
    - Out of range: RDATA=0, RRESP=10.
    - mem_REN stays 0, so RDATA is stable until RVALID&&RREADY.
  - On the R handshake edge: go to R_IDLE; ARREADY=1 the next cycle.
  - Latency: AR handshake on E0 → RVALID in cycle after E1.
- Concurrency and ordering:
  - Write and read FSMs never block each other.
  - If mem_WEN and mem_REN are in the same cycle to the same index, the read returns the pre-write data (memory read-before-write).
  - Only one outstanding transaction per channel pair; no reordering.
- Holding VALID with READY low is legal on all inputs; nothing is accepted without a handshake.

Test Plan:
- Reset low 3 cycles, then high → all VALID/READY=0 during reset; AWREADY=WREADY=ARREADY=1 in the first cycle after release; BRESP=RRESP=00.
- AW=0x08 and W=0xDEADBEEF with WSTRB=1111 on the same edge, BREADY=1 → mem_WEN one cycle with mem_AWADDR=2; BVALID/BRESP=00 next cycle. Then AR=0x08 → RVALID two cycles after the handshake with RDATA=0xDEADBEEF, RRESP=00.
- W issued 3 cycles before AW, WSTRB=0010, WDATA=0x0000AB00, to a word holding 0x11223344 → mem_WEN only after AW accepted; readback=0x1122AB44.
- AW=0x100 (index out of range, dataDepth=64) → mem_WEN never asserted; BRESP=10. AR=0x100 → mem_REN never asserted; RDATA=0, RRESP=10.
- BREADY and RREADY held low 5 cycles → BVALID, RVALID, RDATA and BRESP stay stable; AWREADY and ARREADY stay 0 until the respective handshake.
- Reset pulsed low during W_RESP and during R_MEM → BVALID/RVALID=0, no response issued; the next write/read completes normally.
